// File: rtl/r200mem.sv
// r200mem: memory-access stage of the r200 pipeline.
// ALU results pass straight through with one cycle of latency. Loads and
// stores go out on a req/ack data-memory port. Completed instructions
// reach writeback as a one-cycle out_valid pulse.
module r200mem (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  func3,
   input  logic [31:0] alu_res,
   input  logic [31:0] store_data,
   input  logic [4:0]  rd,
   input  logic        rd_we,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        out_valid,
   output logic [4:0]  out_rd,
   output logic        out_we,
   output logic [31:0] out_data,
   output logic        fault
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   // Context of the in-flight memory op, needed again when the ack arrives
   typedef struct packed {
      logic       is_load;
      logic [2:0] func3;
      logic [1:0] off;
      logic [4:0] rd;
      logic       rd_we;
   } mreq_t;

   state_t      state, state_nxt;
   mreq_t       mq;
   logic        accept, is_mem, f3_ok, aligned, mem_go, mem_bad, ack_hit;
   logic [3:0]  st_be;
   logic [31:0] st_wdata, ld_sh, ld_val;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid & in_ready;
   assign is_mem   = is_load | is_store;
   assign mem_go   = accept & is_mem & f3_ok & aligned;
   assign mem_bad  = accept & is_mem & ~(f3_ok & aligned);
   // BUSY always has dmem_req high; the extra term keeps acks outside a request inert
   assign ack_hit  = (state == BUSY) & dmem_req & dmem_ack;

   // Legal func3 encodings and natural alignment of the incoming access
   always_comb begin
      f3_ok = 1'b0;
      if (is_load)
         f3_ok = (func3 == 3'd0) || (func3 == 3'd1) || (func3 == 3'd2) ||
                 (func3 == 3'd4) || (func3 == 3'd5);
      else if (is_store)
         f3_ok = (func3 == 3'd0) || (func3 == 3'd1) || (func3 == 3'd2);
      case (func3[1:0])
         2'b01:   aligned = ~alu_res[0];
         2'b10:   aligned = (alu_res[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
   end

   // Store lane placement: replicate data so any enabled lane sees the right bytes
   always_comb begin
      case (func3[1:0])
         2'b00: begin
            st_be    = 4'b0001 << alu_res[1:0];
            st_wdata = {4{store_data[7:0]}};
         end
         2'b01: begin
            st_be    = alu_res[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{store_data[15:0]}};
         end
         default: begin
            st_be    = 4'b1111;
            st_wdata = store_data;
         end
      endcase
   end

   // Load extract: bring the addressed lane to bit 0, then extend
   always_comb begin
      ld_sh = dmem_rdata >> {mq.off, 3'b000};
      case (mq.func3)
         3'd0:    ld_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
         3'd1:    ld_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
         3'd4:    ld_val = {24'd0, ld_sh[7:0]};
         3'd5:    ld_val = {16'd0, ld_sh[15:0]};
         default: ld_val = ld_sh;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state: IDLE->BUSY on a legal memory op, BUSY->IDLE on ack
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (mem_go)  state_nxt = BUSY;
         BUSY:    if (ack_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Memory port, request context and writeback output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= 32'd0;
         dmem_wdata <= 32'd0;
         dmem_be    <= 4'd0;
         mq         <= '0;
         out_valid  <= 1'b0;
         out_rd     <= 5'd0;
         out_we     <= 1'b0;
         out_data   <= 32'd0;
         fault      <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         fault     <= 1'b0;
         if (accept && !is_mem) begin
            out_valid <= 1'b1;
            out_rd    <= rd;
            out_we    <= rd_we;
            out_data  <= alu_res;
         end else if (mem_bad) begin
            out_valid <= 1'b1;
            fault     <= 1'b1;
            out_rd    <= rd;
            out_we    <= 1'b0;
            out_data  <= alu_res;
         end else if (mem_go) begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {alu_res[31:2], 2'b00};
            dmem_be    <= is_store ? st_be : 4'd0;
            dmem_wdata <= is_store ? st_wdata : 32'd0;
            mq         <= '{is_load: is_load, func3: func3, off: alu_res[1:0],
                            rd: rd, rd_we: rd_we};
         end
         if (ack_hit) begin
            dmem_req  <= 1'b0;
            out_valid <= 1'b1;
            out_rd    <= mq.rd;
            out_we    <= mq.is_load & mq.rd_we;
            out_data  <= mq.is_load ? ld_val : 32'd0;
         end
      end
   end

endmodule
